// File: rtl/rf_pkg.sv
// Shared constants for the register-file write arbiter slice.
//   RF_DATA_W / RF_ADDR_W : default write-data and register-index widths
//   REG_ZERO              : hard-wired zero register index (writes discarded)
//   SRC_ALU / SRC_MC      : requester indices (single-cycle path, multi-cycle unit)
package rf_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;

  localparam int unsigned REG_ZERO = 0;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MC  = 1'b1;

endpackage : rf_pkg

// File: rtl/rf_fwd_mux.sv
// Read-port bypass: substitutes the staged write data for the register-file
// read data when the staged write targets the register being read.
//   sel        : read index presented to the register file
//   raw        : data returned by the register file
//   stage_we   : staged write is live
//   stage_rd   : staged write destination
//   stage_data : staged write data
//   data       : read data after forwarding (combinational)
module rf_fwd_mux
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W
) (
  input  logic [ADDR_W-1:0] sel,
  input  logic [DATA_W-1:0] raw,
  input  logic              stage_we,
  input  logic [ADDR_W-1:0] stage_rd,
  input  logic [DATA_W-1:0] stage_data,
  output logic [DATA_W-1:0] data
);

  logic hit;

  // Register zero never forwards; it always reads whatever the file returns.
  assign hit  = stage_we && (stage_rd == sel) && (sel != ADDR_W'(REG_ZERO));
  assign data = hit ? stage_data : raw;

endmodule : rf_fwd_mux

// File: rtl/rf_write_arbiter.sv
// Shares the register file's single write port between the single-cycle
// ALU/load path (requester 0) and a multi-cycle unit (requester 1).
// One write per cycle is granted and captured in a registered write stage,
// which is also forwarded to both read ports.
//   clk, reset            : clock, async active-high reset
//   rr_en                 : 1 = round-robin, 0 = fixed priority (req0 wins)
//   wb_stall              : blocks all grants this cycle
//   reqN_valid/rd/data    : write requests
//   reqN_ready            : grant (combinational)
//   reg_write/rd_sel/wb_data/wb_src : registered write stage
//   rsK_sel/rsK_raw       : register-file read index and data
//   rsK_data              : read data after forwarding (combinational)
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rr_en,
  input  logic              wb_stall,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_rd,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_rd,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic              reg_write,
  output logic [ADDR_W-1:0] rd_sel,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_src,
  input  logic [ADDR_W-1:0] rs1_sel,
  input  logic [ADDR_W-1:0] rs2_sel,
  input  logic [DATA_W-1:0] rs1_raw,
  input  logic [DATA_W-1:0] rs2_raw,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data
);

  logic              last_grant;
  logic              grant0;
  logic              grant1;
  logic              accept;
  logic              winner;
  logic [ADDR_W-1:0] win_rd;
  logic [DATA_W-1:0] win_data;

  // Grant selection. Under contention in round-robin mode the requester that
  // did not win last time goes; otherwise requester 0 has priority.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!wb_stall) begin
      if (req0_valid && req1_valid) begin
        if (rr_en && (last_grant == SRC_ALU)) begin
          grant1 = 1'b1;
        end else begin
          grant0 = 1'b1;
        end
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Grants are only raised against a valid request, so any grant is a handshake.
  assign accept   = grant0 | grant1;
  assign winner   = grant1 ? SRC_MC : SRC_ALU;
  assign win_rd   = grant1 ? req1_rd   : req0_rd;
  assign win_data = grant1 ? req1_data : req0_data;

  // Write stage and round-robin pointer. Pointer resets to SRC_MC so the
  // first contention after reset goes to requester 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= SRC_MC;
      reg_write  <= 1'b0;
      rd_sel     <= '0;
      wb_data    <= '0;
      wb_src     <= SRC_ALU;
    end else if (accept) begin
      last_grant <= winner;
      reg_write  <= (win_rd != ADDR_W'(REG_ZERO));
      rd_sel     <= win_rd;
      wb_data    <= win_data;
      wb_src     <= winner;
    end else begin
      reg_write  <= 1'b0;
    end
  end

  // One bypass per read port.
  rf_fwd_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fwd_rs1 (
    .sel        (rs1_sel),
    .raw        (rs1_raw),
    .stage_we   (reg_write),
    .stage_rd   (rd_sel),
    .stage_data (wb_data),
    .data       (rs1_data)
  );

  rf_fwd_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fwd_rs2 (
    .sel        (rs2_sel),
    .raw        (rs2_raw),
    .stage_we   (reg_write),
    .stage_rd   (rd_sel),
    .stage_data (wb_data),
    .data       (rs2_data)
  );

endmodule : rf_write_arbiter

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios followed by
// randomized traffic, checked against a behavioural model and a scoreboard.
module tb_rf_write_arbiter;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        src;
  } stage_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        rr_en, wb_stall;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_rd, req1_rd;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        reg_write;
  logic [4:0]  rd_sel;
  logic [31:0] wb_data;
  logic        wb_src;
  logic [4:0]  rs1_sel, rs2_sel;
  logic [31:0] rs1_raw, rs2_raw, rs1_data, rs2_data;

  int total = 0;
  int bad   = 0;

  // Reference model state
  stage_t      sb[$];
  stage_t      m_stage;
  int          m_last;
  logic        p_v[2];
  logic [4:0]  p_rd[2];
  logic [31:0] p_d[2];
  int          obs;

  always #5 clk = ~clk;

  rf_write_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .rr_en      (rr_en),
    .wb_stall   (wb_stall),
    .req0_valid (req0_valid),
    .req0_rd    (req0_rd),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_rd    (req1_rd),
    .req1_data  (req1_data),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .reg_write  (reg_write),
    .rd_sel     (rd_sel),
    .wb_data    (wb_data),
    .wb_src     (wb_src),
    .rs1_sel    (rs1_sel),
    .rs2_sel    (rs2_sel),
    .rs1_raw    (rs1_raw),
    .rs2_raw    (rs2_raw),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] s, input logic [31:0] r);
    if (m_stage.we && m_stage.rd == s && s != 5'd0) return m_stage.data;
    return r;
  endfunction

  function automatic logic [4:0] rnd_rd();
    if ($urandom_range(0, 7) == 0) return 5'd0;
    return 5'($urandom_range(1, 31));
  endfunction

  task automatic set_req(input int i, input logic [4:0] rd, input logic [31:0] d);
    p_v[i] = 1'b1; p_rd[i] = rd; p_d[i] = d;
  endtask

  // One cycle: drive at negedge, check combinational outputs, queue the
  // expected write stage for the coming edge, then wait for the next negedge.
  task automatic step(input logic stall, input logic rr);
    int w;
    stage_t nxt;
    wb_stall   = stall;
    rr_en      = rr;
    req0_valid = p_v[0]; req0_rd = p_rd[0]; req0_data = p_d[0];
    req1_valid = p_v[1]; req1_rd = p_rd[1]; req1_data = p_d[1];
    rs1_sel = ($urandom_range(0, 1) != 0) ? m_stage.rd : 5'($urandom);
    rs2_sel = ($urandom_range(0, 1) != 0) ? m_stage.rd : 5'($urandom);
    rs1_raw = $urandom;
    rs2_raw = $urandom;
    #1;
    w = -1;
    if (!stall) begin
      if (p_v[0] && p_v[1]) w = rr ? (1 - m_last) : 0;
      else if (p_v[0])      w = 0;
      else if (p_v[1])      w = 1;
    end
    chk("req0_ready", 64'(req0_ready), 64'(w == 0));
    chk("req1_ready", 64'(req1_ready), 64'(w == 1));
    chk("rs1_data", 64'(rs1_data), 64'(fwd(rs1_sel, rs1_raw)));
    chk("rs2_data", 64'(rs2_data), 64'(fwd(rs2_sel, rs2_raw)));
    obs = req1_ready ? 1 : (req0_ready ? 0 : -1);
    if (w >= 0) begin
      nxt.we   = (p_rd[w] != 5'd0);
      nxt.rd   = p_rd[w];
      nxt.data = p_d[w];
      nxt.src  = (w == 1);
      m_last   = w;
      p_v[w]   = 1'b0;
    end else begin
      nxt    = m_stage;
      nxt.we = 1'b0;
    end
    sb.push_back(nxt);
    m_stage = nxt;
    @(negedge clk);
  endtask

  task automatic chk_reset_vals();
    chk("rst_reg_write", 64'(reg_write), 64'(0));
    chk("rst_rd_sel",    64'(rd_sel),    64'(0));
    chk("rst_wb_data",   64'(wb_data),   64'(0));
    chk("rst_wb_src",    64'(wb_src),    64'(0));
  endtask

  // Asynchronous reset applied at a negedge, held across one rising edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk_reset_vals();
    m_stage = '0;
    m_last  = 1;
    sb.push_back('0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: one scoreboard entry per rising edge once traffic starts.
  initial begin
    stage_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("stage_we",   64'(reg_write), 64'(e.we));
        if (e.we || reset) chk("stage_rd", 64'(rd_sel), 64'(e.rd));
        else               chk("stage_rd_hold", 64'(rd_sel), 64'(e.rd));
        chk("stage_data", 64'(wb_data),   64'(e.data));
        chk("stage_src",  64'(wb_src),    64'(e.src));
      end
    end
  end

  initial begin
    int lw;
    int g[4];
    reset = 1'b1; rr_en = 1'b0; wb_stall = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_rd = '0; req1_rd = '0; req0_data = '0; req1_data = '0;
    rs1_sel = '0; rs2_sel = '0; rs1_raw = '0; rs2_raw = '0;
    p_v[0] = 1'b0; p_v[1] = 1'b0;
    p_rd[0] = '0; p_rd[1] = '0; p_d[0] = '0; p_d[1] = '0;
    m_stage = '0; m_last = 1; obs = -1;
    @(negedge clk);
    #1;
    chk_reset_vals();
    @(negedge clk);
    reset = 1'b0;

    // req0 alone, then forwarded read of the staged write
    set_req(0, 5'd5, 32'hDEAD_BEEF);
    step(1'b0, 1'b0);
    chk("t1_grant", 64'(obs), 64'(0));
    rs1_sel = 5'd5; rs1_raw = 32'h0;
    #1;
    chk("t1_fwd", 64'(rs1_data), 64'(32'hDEAD_BEEF));
    chk("t1_rd_sel", 64'(rd_sel), 64'(5));
    step(1'b0, 1'b0);

    // Fresh reset: round-robin contention alternates starting with req0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_req(0, 5'(i + 1), $urandom);
      set_req(1, 5'(i + 10), $urandom);
      step(1'b0, 1'b1);
      g[i] = obs;
    end
    chk("rr_g0", 64'(g[0]), 64'(0));
    chk("rr_g1", 64'(g[1]), 64'(1));
    chk("rr_g2", 64'(g[2]), 64'(0));
    chk("rr_g3", 64'(g[3]), 64'(1));

    // Fixed priority: req0 wins every contended cycle
    for (int i = 0; i < 3; i++) begin
      set_req(0, 5'(i + 20), $urandom);
      set_req(1, 5'd7, 32'h7777_0000);
      step(1'b0, 1'b0);
      chk("fp_grant", 64'(obs), 64'(0));
    end
    p_v[1] = 1'b0;

    // req1 writing register zero: accepted, write discarded
    p_v[0] = 1'b0;
    set_req(1, 5'd0, 32'h1234);
    step(1'b0, 1'b0);
    chk("r0_grant", 64'(obs), 64'(1));
    rs1_sel = 5'd0; rs1_raw = 32'h0;
    #1;
    chk("r0_reg_write", 64'(reg_write), 64'(0));
    chk("r0_rs1", 64'(rs1_data), 64'(0));

    // Stall with both valid, then release in round-robin mode
    lw = m_last;
    set_req(0, 5'd3, 32'hAAAA_0003);
    set_req(1, 5'd4, 32'hBBBB_0004);
    step(1'b1, 1'b1);
    chk("stall_grant0", 64'(obs), 64'(-1));
    step(1'b1, 1'b1);
    chk("stall_grant1", 64'(obs), 64'(-1));
    step(1'b0, 1'b1);
    chk("stall_release", 64'(obs), 64'(1 - lw));
    step(1'b0, 1'b1);

    // Reset the cycle after a handshake; first contention then goes to req0
    set_req(0, 5'd9, 32'h9999_9999);
    step(1'b0, 1'b1);
    chk("pre_rst_we", 64'(reg_write), 64'(1));
    do_reset();
    set_req(0, 5'd11, $urandom);
    set_req(1, 5'd12, $urandom);
    step(1'b0, 1'b1);
    chk("post_rst_grant", 64'(obs), 64'(0));

    // Randomized traffic with occasional stalls, mode flips and resets
    for (int c = 0; c < 400; c++) begin
      logic st, rr;
      for (int i = 0; i < 2; i++)
        if (!p_v[i] && $urandom_range(0, 3) != 0) set_req(i, rnd_rd(), $urandom);
      st = ($urandom_range(0, 6) == 0);
      rr = (c % 50 < 30) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 60) == 0) do_reset();
      step(st, rr);
    end

    @(posedge clk);
    #2;
    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rf_write_arbiter

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the register file's single write port between two writeback requesters: requester 0 is the single-cycle ALU/load path and requester 1 is a multi-cycle unit. Grants use round-robin or fixed priority, and each cycle at most one write is accepted and placed in a registered write stage that drives the register file's write controls. The block also forwards the staged write to the two read ports, so a read issued in the same cycle as an in-flight write returns the new value.

## Interface
Parameters:
- DATA_W, 32, width of the write data.
- ADDR_W, 5, width of the register index.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- rr_en  in  1  1 selects round-robin arbitration, 0 selects fixed priority with requester 0 winning.
- wb_stall  in  1  1 blocks all grants this cycle.
- req0_valid / req1_valid  in  1  write request is present.
- req0_rd / req1_rd  in  ADDR_W  destination register index.
- req0_data / req1_data  in  DATA_W  write data.
- req0_ready / req1_ready  out  1  grant; combinational from valids, rr_en, wb_stall and the pointer.
- reg_write  out  1  registered write enable to the register file.
- rd_sel  out  ADDR_W  registered destination index.
- wb_data  out  DATA_W  registered write data.
- wb_src  out  1  requester that owns the staged write.
- rs1_sel / rs2_sel  in  ADDR_W  read indices, sampled at the register file.
- rs1_raw / rs2_raw  in  DATA_W  read data from the register file.
- rs1_data / rs2_data  out  DATA_W  read data after forwarding.

## Operation
- A handshake happens when reqN_valid and reqN_ready are both 1 at a rising edge. A requester holds valid, rd and data stable until its handshake.
- Ready rules:
  - When wb_stall=1, both ready outputs are 0.
  - When only one valid is asserted, that requester gets ready.
  - When both valids are asserted and rr_en=0, requester 0 gets ready.
  - When both valids are asserted and rr_en=1, the requester that is not last_grant gets ready.
- last_grant is a 1-bit register. It updates to the granted index on every handshake, in both modes, and is unchanged when no handshake occurs.
- Write stage on a handshake:
  - rd_sel and wb_data load from the winner; wb_src loads the winner index.
  - reg_write loads 1 if the winner's rd is nonzero. For rd=0, reg_write loads 0: the request is accepted and the write is discarded.
- With no handshake, reg_write loads 0, and rd_sel, wb_data and wb_src hold their values.
- Forwarding: rsK_data = wb_data when reg_write=1, rd_sel=rsK_sel and rsK_sel≠0. Otherwise rsK_data = rsK_raw. Forwarding is purely combinational.
- A requester whose rd is 0 still receives ready normally.

## Timing
- Values after reset: reg_write=0, rd_sel=0, wb_data=0, wb_src=0, last_grant=1. With last_grant=1, the first contention goes to requester 0.
- Latency:
  - Handshake at edge N → reg_write=1 during cycle N..N+1.
  - The register file commits the write at edge N+1.
  - Forwarding covers the reads during cycle N..N+1.
- Throughput: one write per cycle sustained.
- Under continuous contention with rr_en=1, grants alternate 0,1,0,1. Worst-case wait is 1 cycle.
- Toggling rr_en takes effect in the same cycle. The pointer is not reset by a mode change.
- wb_stall asserted while a write is staged: the staged write still completes. No new grant is made, so reg_write drops the following cycle.
- Reset asserted mid-operation: a staged write is lost, and reg_write deasserts asynchronously. Requesters retain their valid and re-handshake after reset is released.
- Both requesters targeting the same rd on consecutive cycles: the writes land in grant order, and the later write overwrites the earlier one.

## Structure
- Shared package rf_pkg holds:
  - the DATA_W and ADDR_W defaults;
  - REG_ZERO = 0;
  - SRC_ALU = 0 and SRC_MC = 1.
- Sub-module rf_fwd_mux, instantiated once per read port: inputs sel, raw, stage_we, stage_rd, stage_data; output data.
- The arbiter and write stage stay in the top module.

## Test plan
- Reset, then req0 only, rd=5, data=0xDEAD_BEEF → req0_ready=1. The next cycle has reg_write=1, rd_sel=5, wb_src=0, and rs1_sel=5 reads 0xDEAD_BEEF through forwarding.
- rr_en=1, both valid for 4 cycles, each requester re-presenting new data → grant sequence 0,1,0,1 and reg_write high for 4 consecutive cycles.
- rr_en=0, both valid for 3 cycles → requester 0 wins all 3, and req1_ready stays 0.
- req1 with rd=0, data=0x1234 → req1_ready=1. Next cycle reg_write=0, and rs1_sel=0 returns rs1_raw (0).
- wb_stall=1 for 2 cycles with both valid → both ready outputs 0 and reg_write 0. Releasing the stall grants the non-last_grant requester.
- Assert reset in the cycle after a handshake → reg_write=0 immediately, all outputs return to their reset values, and last_grant=1.
